// File: rtl/max7219_chain_tx.sv
// -----------------------------------------------------------------------------
// max7219_chain_tx
//
// Serial transmitter for a daisy-chain of MAX7219 LED matrix drivers.
// One 16-bit command word per device is captured in parallel. The words are
// shifted out MSB-first on a shared DIN/CLK pair. Device G_MATRIX_NB-1's word
// goes first and device 0's word goes last, so each word ends up in its own
// device. A LOAD pulse then latches every device at the same time.
//
// Optional feature (macro MAX7219_CHAIN_TX_INIT_SEQ_EN):
//   When the macro is defined, the block sends five broadcast set-up transfers
//   on its own after reset is released: 0x0C01, 0x0B07, 0x0900, 0x0A08, 0x0F00.
//   o_busy stays high for the whole sequence. o_done pulses once, after the
//   last transfer. i_start is ignored until the sequence has finished.
//
// Parameters:
//   G_MATRIX_NB   : number of devices in the chain (1..8)
//   G_CLK_DIV     : clk cycles per serial clock phase (low and high), >= 1
//   G_LOAD_CYCLES : clk cycles that LOAD is held high, >= 1
//
// Ports:
//   clk            : system clock
//   rst_n          : asynchronous active-low reset
//   i_start        : request one chain transfer (sampled only when not busy)
//   i_data         : command words, i_data[16*k+15:16*k] for device k
//   o_max7219_clk  : serial clock to the chain
//   o_max7219_din  : serial data to device 0
//   o_max7219_load : latch strobe (rising edge latches all devices)
//   o_busy         : transfer in progress
//   o_done         : one-cycle pulse when a transfer completes
// -----------------------------------------------------------------------------
module max7219_chain_tx #(
  parameter int G_MATRIX_NB   = 2,
  parameter int G_CLK_DIV     = 4,
  parameter int G_LOAD_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic [16*G_MATRIX_NB-1:0] i_data,
  output logic                      o_max7219_clk,
  output logic                      o_max7219_din,
  output logic                      o_max7219_load,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int N      = 16 * G_MATRIX_NB;
  localparam int PH_MAX = (G_CLK_DIV > G_LOAD_CYCLES) ? G_CLK_DIV : G_LOAD_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int BC_W   = $clog2(N + 1);

  localparam logic [PH_W-1:0] DIV_LAST  = PH_W'(G_CLK_DIV - 1);
  localparam logic [PH_W-1:0] LOAD_LAST = PH_W'(G_LOAD_CYCLES - 1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t          state;
  logic [N-1:0]    shift;
  logic [PH_W-1:0] phase_cnt;
  logic [BC_W-1:0] bit_cnt;

  // Launch request and frame to send, valid in IDLE (and, for the init
  // sequence, in the gap cycle between two set-up transfers).
  logic         go;
  logic [N-1:0] go_frame;

`ifdef MAX7219_CHAIN_TX_INIT_SEQ_EN
  logic         init_pending;
  logic [2:0]   init_idx;      // number of set-up transfers launched so far
  logic [N-1:0] init_frame;

  function automatic logic [15:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'h0C01;  // shutdown off
      3'd1:    return 16'h0B07;  // scan limit 7
      3'd2:    return 16'h0900;  // no decode
      3'd3:    return 16'h0A08;  // intensity 8
      3'd4:    return 16'h0F00;  // display test off
      default: return 16'h0000;
    endcase
  endfunction

  assign init_frame = {G_MATRIX_NB{init_word(init_idx)}};
`endif

  always_comb begin
    go       = 1'b0;
    go_frame = i_data;
    case (state)
      ST_IDLE: begin
`ifdef MAX7219_CHAIN_TX_INIT_SEQ_EN
        // A pending init sequence takes priority and masks i_start.
        go       = init_pending | i_start;
        go_frame = init_pending ? init_frame : i_data;
`else
        go       = i_start;
`endif
      end
      ST_DONE: begin
`ifdef MAX7219_CHAIN_TX_INIT_SEQ_EN
        // The gap cycle between set-up transfers launches the next one directly.
        go       = init_pending;
        go_frame = init_frame;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      shift          <= '0;
      phase_cnt      <= '0;
      bit_cnt        <= '0;
      o_max7219_clk  <= 1'b0;
      o_max7219_din  <= 1'b0;
      o_max7219_load <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
`ifdef MAX7219_CHAIN_TX_INIT_SEQ_EN
      init_pending   <= 1'b1;
      init_idx       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          o_done <= 1'b0;
          if (go) begin
            shift          <= go_frame;
            state          <= ST_BIT_LOW;
            phase_cnt      <= '0;
            bit_cnt        <= '0;
            o_max7219_clk  <= 1'b0;
            o_max7219_din  <= go_frame[N-1];
            o_max7219_load <= 1'b0;
            o_busy         <= 1'b1;
`ifdef MAX7219_CHAIN_TX_INIT_SEQ_EN
            if (init_pending) begin
              init_idx <= init_idx + 3'd1;
            end
`endif
          end else begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end

        ST_BIT_LOW: begin
          if (phase_cnt == DIV_LAST) begin
            phase_cnt     <= '0;
            state         <= ST_BIT_HIGH;
            o_max7219_clk <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        ST_BIT_HIGH: begin
          if (phase_cnt == DIV_LAST) begin
            phase_cnt     <= '0;
            shift         <= shift << 1;
            bit_cnt       <= bit_cnt + 1'b1;
            o_max7219_clk <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state          <= ST_LOAD;
              o_max7219_din  <= 1'b0;
              o_max7219_load <= 1'b1;
            end else begin
              state         <= ST_BIT_LOW;
              // Next bit is the one just below the current MSB.
              o_max7219_din <= shift[N-2];
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        ST_LOAD: begin
          if (phase_cnt == LOAD_LAST) begin
            phase_cnt      <= '0;
            o_max7219_load <= 1'b0;
            state          <= ST_DONE;
`ifdef MAX7219_CHAIN_TX_INIT_SEQ_EN
            if (init_pending && init_idx != 3'd5) begin
              // Gap cycle: stay busy and hold o_done low until the last set-up word.
              o_busy <= 1'b1;
              o_done <= 1'b0;
            end else begin
              init_pending <= 1'b0;
              o_busy       <= 1'b0;
              o_done       <= 1'b1;
            end
`else
            o_busy <= 1'b0;
            o_done <= 1'b1;
`endif
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_chain_tx.sv
// -----------------------------------------------------------------------------
// tb_max7219_chain_tx
//
// Bench for max7219_chain_tx with G_MATRIX_NB=2, G_CLK_DIV=2, G_LOAD_CYCLES=2.
// A timeline model predicts every output from the number of cycles elapsed
// since a start was accepted. A small chain emulator shifts on the rising
// edge of o_max7219_clk and latches on the rising edge of o_max7219_load.
// Directed tests pin the results with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_max7219_chain_tx;

  localparam int NB    = 2;
  localparam int D     = 2;
  localparam int L     = 2;
  localparam int N     = 16 * NB;
  localparam int TOTAL = N * 2 * D + L;   // busy cycles per transfer (130)

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic [N-1:0] i_data;
  logic         o_max7219_clk;
  logic         o_max7219_din;
  logic         o_max7219_load;
  logic         o_busy;
  logic         o_done;

  always #5 clk = ~clk;

  max7219_chain_tx #(
    .G_MATRIX_NB  (NB),
    .G_CLK_DIV    (D),
    .G_LOAD_CYCLES(L)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_data        (i_data),
    .o_max7219_clk (o_max7219_clk),
    .o_max7219_din (o_max7219_din),
    .o_max7219_load(o_max7219_load),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- timeline model ----------------
  int           m_e;            // cycles since accept, -1 when idle
  logic [N-1:0] m_frame;
  int           m_init_left;    // set-up transfers still to launch

  function automatic logic [N-1:0] init_frame(input int idx);
    logic [15:0] w;
    case (idx)
      0:       w = 16'h0C01;
      1:       w = 16'h0B07;
      2:       w = 16'h0900;
      3:       w = 16'h0A08;
      default: w = 16'h0F00;
    endcase
    return {NB{w}};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e = -1;
`ifdef MAX7219_CHAIN_TX_INIT_SEQ_EN
      m_init_left = 5;
`else
      m_init_left = 0;
`endif
    end else if (m_e == TOTAL) begin
      if (m_init_left > 0) begin
        m_frame = init_frame(5 - m_init_left);
        m_init_left--;
        m_e = 0;
      end else begin
        m_e = -1;
      end
    end else if (m_e >= 0) begin
      m_e++;
    end else if (m_init_left > 0) begin
      m_frame = init_frame(5 - m_init_left);
      m_init_left--;
      m_e = 0;
    end else if (i_start) begin
      m_frame = i_data;
      m_e = 0;
    end
  end

  // ---------------- compare process ----------------
  int busy_run = 0;
  int last_run = 0;
  int done_cnt = 0;

  always @(negedge clk) begin : cmp
    logic ec, ed, el, eb, edn;
    ec = 0; ed = 0; el = 0; eb = 0; edn = 0;
    if (rst_n && m_e >= 0) begin
      if (m_e < N * 2 * D) begin
        ec = (m_e % (2 * D)) >= D;
        ed = m_frame[N - 1 - m_e / (2 * D)];
        eb = 1;
      end else if (m_e < TOTAL) begin
        el = 1;
        eb = 1;
      end else if (m_init_left > 0) begin
        eb = 1;
      end else begin
        edn = 1;
      end
    end
    chk("cyc_sclk", o_max7219_clk, ec);
    chk("cyc_din",  o_max7219_din, ed);
    chk("cyc_load", o_max7219_load, el);
    chk("cyc_busy", o_busy, eb);
    chk("cyc_done", o_done, edn);
    if (o_busy) busy_run++;
    else if (o_done) begin
      last_run = busy_run;
      busy_run = 0;
      done_cnt++;
    end else busy_run = 0;
  end

  // ---------------- chain emulator ----------------
  logic [N-1:0] em_sh = '0;
  logic [15:0]  em_word[NB];
  logic [7:0]   em_reg[NB][16];
  int rise_cnt = 0;
  int load_cnt = 0;

  initial begin
    for (int k = 0; k < NB; k++) begin
      em_word[k] = '0;
      for (int a = 0; a < 16; a++) em_reg[k][a] = '0;
    end
  end

  always @(posedge o_max7219_clk) begin
    em_sh = {em_sh[N-2:0], o_max7219_din};
    rise_cnt++;
  end

  always @(posedge o_max7219_load) begin
    load_cnt++;
    for (int k = 0; k < NB; k++) begin
      em_word[k] = em_sh[16*k +: 16];
      em_reg[k][em_sh[16*k+8 +: 4]] = em_sh[16*k +: 8];
    end
  end

  // ---------------- stimulus ----------------
  task automatic start(input logic [N-1:0] d);
    @(negedge clk);
    i_data  = d;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (o_done) found = 1;
    end
    chk({nm, "_done_seen"}, found, 1);
  endtask

  int r0, l0, d0;

  initial begin
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", o_max7219_clk, 0);
    chk("rst_din",  o_max7219_din, 0);
    chk("rst_load", o_max7219_load, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    rst_n = 1'b1;

`ifdef MAX7219_CHAIN_TX_INIT_SEQ_EN
    l0 = load_cnt;
    d0 = done_cnt;
    i_data  = {16'h0111, 16'h0222};
    i_start = 1'b1;
    repeat (20) @(negedge clk);
    i_start = 1'b0;
    wait_done("init");
    repeat (2) @(negedge clk);
    chk("init_loads", load_cnt - l0, 5);
    chk("init_dones", done_cnt - d0, 1);
    for (int k = 0; k < NB; k++) begin
      chk("init_word", em_word[k], 16'h0F00);
      chk("init_reg_c", em_reg[k][12], 8'h01);
      chk("init_reg_b", em_reg[k][11], 8'h07);
      chk("init_reg_a", em_reg[k][10], 8'h08);
    end
`endif

    // Test 1: basic transfer.
    r0 = rise_cnt; l0 = load_cnt; d0 = done_cnt;
    start({16'h0155, 16'h02AA});
    wait_done("t1");
    repeat (2) @(negedge clk);
    chk("t1_rises", rise_cnt - r0, 32);
    chk("t1_busy_len", last_run, 130);
    chk("t1_loads", load_cnt - l0, 1);
    chk("t1_dones", done_cnt - d0, 1);
    chk("t1_dev0_word", em_word[0], 16'h02AA);
    chk("t1_dev1_word", em_word[1], 16'h0155);
    chk("t1_dev0_reg2", em_reg[0][2], 8'hAA);
    chk("t1_dev1_reg1", em_reg[1][1], 8'h55);

    // Test 2: i_start and i_data change during a transfer are ignored.
    d0 = done_cnt;
    start({16'h0C55, 16'h0B33});
    repeat (8) @(negedge clk);
    i_data  = {16'h0A77, 16'h0966};
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done("t2");
    repeat (12) @(negedge clk);
    chk("t2_dev0_word", em_word[0], 16'h0B33);
    chk("t2_dev1_word", em_word[1], 16'h0C55);
    chk("t2_dones", done_cnt - d0, 1);
    chk("t2_idle_after", o_busy, 0);

    // Test 3: start in the done cycle is ignored, accepted on the next cycle.
    start({16'h0A01, 16'h0A02});
    wait_done("t3a");
    i_data  = {16'h0303, 16'h0404};
    i_start = 1'b1;
    chk("t3_busy_in_done", o_busy, 0);
    @(negedge clk);
    chk("t3_busy_idle_cycle", o_busy, 0);
    @(negedge clk);
    chk("t3_busy_started", o_busy, 1);
    i_start = 1'b0;
    wait_done("t3b");
    repeat (2) @(negedge clk);
    chk("t3_dev0_word", em_word[0], 16'h0404);
    chk("t3_dev1_word", em_word[1], 16'h0303);

    // Test 4: reset after 20 bits, then a clean transfer.
    r0 = rise_cnt; l0 = load_cnt;
    start({16'h0155, 16'h0155});
    for (int k = 0; k < 1000 && (rise_cnt - r0) < 20; k++) @(negedge clk);
    chk("t4_bits_reached", (rise_cnt - r0) >= 20, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_sclk", o_max7219_clk, 0);
    chk("t4_rst_din",  o_max7219_din, 0);
    chk("t4_rst_load", o_max7219_load, 0);
    chk("t4_rst_busy", o_busy, 0);
    chk("t4_rst_done", o_done, 0);
    repeat (3) @(negedge clk);
    chk("t4_no_load", load_cnt - l0, 0);
    rst_n = 1'b1;
`ifdef MAX7219_CHAIN_TX_INIT_SEQ_EN
    wait_done("t4_init");
    l0 = load_cnt;
`endif
    start({16'h0F01, 16'h0F01});
    wait_done("t4");
    repeat (2) @(negedge clk);
    chk("t4_loads", load_cnt - l0, 1);
    chk("t4_dev0_word", em_word[0], 16'h0F01);
    chk("t4_dev1_word", em_word[1], 16'h0F01);
    chk("t4_dev0_regf", em_reg[0][15], 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
